// File: rtl/lc3_mem_pkg.sv
// Shared types and address map for the LC-3 memory responder.
// Device addresses are only decoded when LC3_MMIO_EN is defined.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  localparam logic [15:0] MMIO_BASE = 16'hFE00;
  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  // The whole xFE00..xFFFF page belongs to devices; unmapped slots read 0.
  function automatic logic is_mmio(input logic [15:0] addr);
    return addr[15:9] == MMIO_BASE[15:9];
  endfunction

endpackage

// File: rtl/lc3_mem_ctrl_if.sv
// CPU-side memory bus: MAR/MDR/MIO_EN/R.W request and the R ready handshake.
interface lc3_mem_ctrl_if;
  logic [15:0] mar;
  logic [15:0] mdr_out;
  logic        mio_en;
  logic        r_w;
  logic [15:0] mem_data;
  logic        mem_r;

  modport master (output mar, output mdr_out, output mio_en, output r_w,
                  input mem_data, input mem_r);
  modport slave  (input mar, input mdr_out, input mio_en, input r_w,
                  output mem_data, output mem_r);
endinterface

// File: rtl/lc3_mmio.sv
// Keyboard (KBSR/KBDR) and display (DSR/DDR) registers with read mux.
// Accessed only through one-cycle strobes issued when an access completes.
module lc3_mmio
  import lc3_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_wdata,
  input  logic        i_rd_en,
  input  logic        i_wr_en,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  input  logic        dd_ready,
  output logic [15:0] o_rdata,
  output logic        dd_valid,
  output logic [7:0]  dd_data
);

  logic       r_kb_ready;
  logic [7:0] r_kbdr;
  logic       r_dd_valid;
  logic [7:0] r_dd_data;
  logic       w_kbdr_rd;
  logic       w_ddr_wr;
  logic       w_unused_wdata;

  assign w_kbdr_rd      = i_rd_en && (i_addr == KBDR_ADDR);
  assign w_ddr_wr       = i_wr_en && (i_addr == DDR_ADDR);
  assign w_unused_wdata = ^i_wdata[15:8];

  // A KBDR read frees the slot in the same edge, so a coincident key is kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_kb_ready <= 1'b0;
      r_kbdr     <= 8'h00;
    end else if (kb_valid && (!r_kb_ready || w_kbdr_rd)) begin
      r_kbdr     <= kb_data;
      r_kb_ready <= 1'b1;
    end else if (w_kbdr_rd) begin
      r_kb_ready <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dd_valid <= 1'b0;
      r_dd_data  <= 8'h00;
    end else if (w_ddr_wr && !r_dd_valid) begin
      r_dd_data  <= i_wdata[7:0];
      r_dd_valid <= 1'b1;
    end else if (r_dd_valid && dd_ready) begin
      r_dd_valid <= 1'b0;
    end
  end

  always_comb begin
    o_rdata = 16'h0000;
    case (i_addr)
      KBSR_ADDR: o_rdata = {r_kb_ready, 15'b0};
      KBDR_ADDR: o_rdata = {8'h00, r_kbdr};
      DSR_ADDR:  o_rdata = {!r_dd_valid, 15'b0};
      default:   o_rdata = 16'h0000;
    endcase
  end

  assign dd_valid = r_dd_valid;
  assign dd_data  = r_dd_data;

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory responder: wait-stated word RAM behind the MAR/MDR bus.
// Define LC3_MMIO_EN to decode keyboard/display registers at xFE00..xFE06.
module lc3_mem_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 3
) (
  input  logic           clk,
  input  logic           reset,
  lc3_mem_ctrl_if.slave  bus,
  input  logic           kb_valid,
  input  logic [7:0]     kb_data,
  output logic           dd_valid,
  output logic [7:0]     dd_data,
  input  logic           dd_ready
);

  localparam logic [3:0] LP_WAIT = 4'(WAIT_STATES);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_wr;
  logic [15:0] r_mem_data;
  logic [15:0] r_ram [0:(1<<ADDR_W)-1];
  logic        w_access;
  logic        w_mmio_hit;
  logic [15:0] w_mmio_rdata;
  logic [15:0] w_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.mio_en) w_state_nxt = ST_BUSY;
      ST_BUSY: if (r_cnt == 4'd0) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_access     = (r_state == ST_BUSY) && (r_cnt == 4'd0);
  assign bus.mem_r    = (r_state == ST_DONE);
  assign bus.mem_data = r_mem_data;
  assign w_rdata      = w_mmio_hit ? w_mmio_rdata : r_ram[r_addr[ADDR_W-1:0]];

  // Request fields are captured once; the bus may change freely afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= 4'd0;
      r_addr     <= 16'h0000;
      r_wdata    <= 16'h0000;
      r_wr       <= 1'b0;
      r_mem_data <= 16'h0000;
    end else begin
      if (r_state == ST_IDLE && bus.mio_en) begin
        r_addr  <= bus.mar;
        r_wdata <= bus.mdr_out;
        r_wr    <= bus.r_w;
        r_cnt   <= LP_WAIT;
      end else if (r_state == ST_BUSY && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access && !r_wr) r_mem_data <= w_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_access && r_wr && !w_mmio_hit) r_ram[r_addr[ADDR_W-1:0]] <= r_wdata;
  end

`ifdef LC3_MMIO_EN
  assign w_mmio_hit = is_mmio(r_addr);

  lc3_mmio u_mmio (
    .clk      (clk),
    .reset    (reset),
    .i_addr   (r_addr),
    .i_wdata  (r_wdata),
    .i_rd_en  (w_access && !r_wr),
    .i_wr_en  (w_access && r_wr),
    .kb_valid (kb_valid),
    .kb_data  (kb_data),
    .dd_ready (dd_ready),
    .o_rdata  (w_mmio_rdata),
    .dd_valid (dd_valid),
    .dd_data  (dd_data)
  );
`else
  logic w_unused_io;
  assign w_mmio_hit   = 1'b0;
  assign w_mmio_rdata = 16'h0000;
  assign dd_valid     = 1'b0;
  assign dd_data      = 8'h00;
  assign w_unused_io  = ^{kb_valid, kb_data, dd_ready, r_addr};
`endif

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Scoreboard bench for lc3_mem_ctrl: default-wait instance plus a zero-wait one.
// Device-register checks follow LC3_MMIO_EN, matching the DUT build.
module tb_lc3_mem_ctrl;
  import lc3_mem_pkg::*;

  localparam int WS = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       kb_valid, dd_ready;
  logic [7:0] kb_data;
  logic       dd_valid, dd_valid0;
  logic [7:0] dd_data, dd_data0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp0_q[$];
  logic [15:0] last_rd, last_rd0, sb_e, sb0_e;

  lc3_mem_ctrl_if bus();
  lc3_mem_ctrl_if bus0();

  lc3_mem_ctrl #(.ADDR_W(12), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset), .bus(bus), .kb_valid(kb_valid), .kb_data(kb_data),
    .dd_valid(dd_valid), .dd_data(dd_data), .dd_ready(dd_ready));

  lc3_mem_ctrl #(.ADDR_W(12), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .kb_valid(1'b0), .kb_data(8'h00),
    .dd_valid(dd_valid0), .dd_data(dd_data0), .dd_ready(1'b1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.mem_r) begin
      if (exp_q.size() == 0) chk("sb_unexpected_memr", 1, 0);
      else begin
        sb_e = exp_q.pop_front();
        chk("sb_data", bus.mem_data, sb_e);
      end
    end
    if (!reset && bus0.mem_r) begin
      if (exp0_q.size() == 0) chk("sb0_unexpected_memr", 1, 0);
      else begin
        sb0_e = exp0_q.pop_front();
        chk("sb0_data", bus0.mem_data, sb0_e);
      end
    end
  end

  task automatic acc(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                     input logic [15:0] exp_rd);
    int n;
    @(negedge clk);
    bus.mar = addr; bus.mdr_out = data; bus.r_w = wr; bus.mio_en = 1'b1;
    if (!wr) last_rd = exp_rd;
    exp_q.push_back(last_rd);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (n == 1) begin
        bus.mar = ~addr; bus.mdr_out = ~data; bus.r_w = ~wr;
      end
    end while (!bus.mem_r && n < 40);
    chk("latency", n, WS + 2);
    bus.mio_en = 1'b0;
    @(posedge clk); #1;
    chk("pulse_width", bus.mem_r, 0);
  endtask

  task automatic kb_pulse(input logic [7:0] c);
    @(negedge clk);
    kb_valid = 1'b1; kb_data = c;
    @(negedge clk);
    kb_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic wr;
    logic [15:0] a, d;
    reset = 1'b1; kb_valid = 1'b0; kb_data = 8'h00; dd_ready = 1'b0;
    bus.mar = 0;  bus.mdr_out = 0;  bus.r_w = 0;  bus.mio_en = 0;
    bus0.mar = 0; bus0.mdr_out = 0; bus0.r_w = 0; bus0.mio_en = 0;
    last_rd = 16'h0000; last_rd0 = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_mem_r", bus.mem_r, 0);
    chk("rst_mem_data", bus.mem_data, 0);
    chk("rst_dd_valid", dd_valid, 0);
    chk("rst_dd_data", dd_data, 0);
    reset = 1'b0;

    acc(1'b1, 16'h3000, 16'h1234, 16'h0);
    acc(1'b0, 16'h3000, 16'h0000, 16'h1234);
    acc(1'b1, 16'h0010, 16'hBEEF, 16'h0);
    acc(1'b0, 16'h1010, 16'h0000, 16'hBEEF);
    acc(1'b1, 16'h0020, 16'h1111, 16'h0);

    // Abandon a write in BUSY: no pulse, no RAM update, mem_data cleared.
    @(negedge clk);
    bus.mar = 16'h0020; bus.mdr_out = 16'h5555; bus.r_w = 1'b1; bus.mio_en = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_mid_busy", bus.mem_r, 0);
    reset = 1'b1; bus.mio_en = 1'b0;
    #1;
    chk("rst_mid_data", bus.mem_data, 0);
    last_rd = 16'h0000;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    acc(1'b0, 16'h0020, 16'h0000, 16'h1111);

`ifdef LC3_MMIO_EN
    kb_pulse(8'h41);
    acc(1'b0, KBSR_ADDR, 16'h0, 16'h8000);
    acc(1'b0, KBDR_ADDR, 16'h0, 16'h0041);
    acc(1'b0, KBSR_ADDR, 16'h0, 16'h0000);
    kb_pulse(8'h43);
    kb_pulse(8'h42);
    acc(1'b0, KBDR_ADDR, 16'h0, 16'h0043);
    acc(1'b1, DDR_ADDR, 16'h0058, 16'h0);
    chk("dd_valid_set", dd_valid, 1);
    chk("dd_data_set", dd_data, 8'h58);
    acc(1'b0, DSR_ADDR, 16'h0, 16'h0000);
    acc(1'b1, DDR_ADDR, 16'h0059, 16'h0);
    chk("dd_data_busy_ignored", dd_data, 8'h58);
    @(negedge clk); dd_ready = 1'b1;
    @(negedge clk); dd_ready = 1'b0;
    chk("dd_valid_clr", dd_valid, 0);
    acc(1'b0, DSR_ADDR, 16'h0, 16'h8000);
    acc(1'b0, 16'hFE08, 16'h0, 16'h0000);
`else
    acc(1'b1, 16'hFE04, 16'hCAFE, 16'h0);
    acc(1'b0, 16'h0E04, 16'h0000, 16'hCAFE);
    kb_pulse(8'h41);
    dd_ready = 1'b1;
    @(negedge clk);
    chk("nommio_dd_valid", dd_valid, 0);
    chk("nommio_dd_data", dd_data, 0);
    dd_ready = 1'b0;
`endif

    // Zero wait states, mio_en held high across back-to-back accesses.
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      wr = (i < 4);
      a  = 16'h0100 + 16'(i % 4);
      d  = 16'hA0A0 ^ (16'(i % 4) * 16'h0111);
      bus0.mar = a; bus0.mdr_out = d; bus0.r_w = wr; bus0.mio_en = 1'b1;
      if (!wr) last_rd0 = d;
      exp0_q.push_back(last_rd0);
      n = 0;
      do begin
        @(posedge clk); #1; n++;
      end while (!bus0.mem_r && n < 40);
      if (i == 0) chk("ws0_first", n, 2);
      else        chk("ws0_period", n, 3);
    end
    bus0.mio_en = 1'b0;
    repeat (3) @(negedge clk);

    chk("sb_drain", exp_q.size(), 0);
    chk("sb0_drain", exp0_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3_mem_ctrl.md
# lc3_mem_ctrl

Memory-side responder for the LC-3 datapath: services the access the CPU presents through the MAR/MDR/MIO_EN/R.W interface and returns the ready (R) handshake. It holds a word-addressed RAM with configurable wait states and decodes the memory-mapped keyboard and display registers. It sits between the datapath's MAR/MDR registers and the board-level keyboard/display adapters.

## Interface
- ADDR_W, 12: RAM address bits; RAM depth 2^ADDR_W words of 16 bits; address uses mar[ADDR_W-1:0], upper bits alias.
- WAIT_STATES, 3: extra busy cycles per access, 0..15.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- mar  in  16  access address; sampled at request acceptance.
- mdr_out  in  16  write data; sampled at request acceptance.
- mio_en  in  1  access request; held high by the requester until mem_r.
- r_w  in  1  1 = write, 0 = read; sampled at request acceptance.
- mem_data  out  16  read data toward MDR.
- mem_r  out  1  ready; one-cycle pulse marking access completion.
- kb_valid  in  1  one-cycle strobe: new keyboard character.
- kb_data  in  8  keyboard character, valid with kb_valid.
- dd_valid  out  1  display character pending.
- dd_data  out  8  display character.
- dd_ready  in  1  display accepts dd_data when dd_valid && dd_ready at a clock edge.

## Operation
- FSM states IDLE, BUSY, DONE.
- IDLE: mio_en high at an edge -> latch mar, mdr_out, r_w; cnt <= WAIT_STATES; go BUSY.
- BUSY: cnt != 0 -> cnt--; cnt == 0 -> perform access, go DONE.
- DONE: mem_r = 1 for exactly this cycle; next state IDLE unconditionally. mio_en high in the cycle after DONE is a new request.
- Read: mem_data loaded at BUSY->DONE edge; holds until next read completes. Write: RAM/register updated at BUSY->DONE edge; mem_data unchanged.
- Changes of mar/mdr_out/r_w after acceptance have no effect.
- Device registers (MMIO build): KBSR xFE00, KBDR xFE02, DSR xFE04, DDR xFE06; full 16-bit match.
- KBSR[15] = keyboard ready; other bits 0. kb_valid with KBSR[15]=0 -> KBDR <= {8'h00,kb_data}, KBSR[15] <= 1. kb_valid with KBSR[15]=1 -> character dropped.
- Read of KBDR clears KBSR[15]. Same edge as kb_valid: read returns old KBDR, new character captured, KBSR[15] stays 1 (set wins).
- DSR[15] = display ready = !dd_valid; other bits 0.
- Write DDR with DSR[15]=1 -> dd_data <= mdr_out[7:0], dd_valid <= 1. Write DDR with DSR[15]=0 -> ignored.
- dd_valid && dd_ready at edge -> dd_valid <= 0.
- Writes to KBSR, KBDR, DSR ignored. Reads of xFE08..xFFFF return 0; writes ignored.

## Timing
- Request first sampled at edge n -> mem_r high in the cycle after edge n+WAIT_STATES+1; WAIT_STATES=0 -> 2-cycle turnaround, default -> 5.
- Back-to-back accesses: WAIT_STATES+3 cycles per access.
- Reset values: mem_r 0, mem_data 0, dd_valid 0, dd_data 0, KBSR 0, KBDR 0, state IDLE, cnt 0. RAM not reset.
- Reset mid-access: access abandoned, no write performed, no mem_r pulse.

## Configuration
- LC3_MMIO_EN defined: device register decode as above.
- Not defined: all addresses go to RAM (aliased); kb_* ignored, dd_valid tied 0, dd_data tied 0.

## Structure
- Package lc3_mem_pkg: state enum, KBSR/KBDR/DSR/DDR address constants, MMIO base xFE00.
- Sub-module lc3_mmio: keyboard/display registers, read mux, DDR handshake; instantiated only under LC3_MMIO_EN.

## Test plan
- Write x1234 to x3000, then read x3000 -> mem_data x1234, mem_r high exactly 1 cycle, 5 cycles after request (default).
- WAIT_STATES=0, back-to-back reads with mio_en held high -> mem_r every 3 cycles, correct data each.
- Alias: write xBEEF to x0010, read x1010 (ADDR_W=12) -> xBEEF.
- kb_valid with x41 -> KBSR read x8000, KBDR read x0041, KBSR then x0000; second kb_valid x42 while ready -> x42 dropped.
- Write DDR x0058 -> dd_valid 1, dd_data x58, DSR x0000; write x59 ignored; dd_ready -> DSR x8000.
- Reset asserted during BUSY of write x5555 to x0020 -> no mem_r; later read x0020 returns prior contents.
